// File: rtl/platform_pkg.sv
// yarc platform constants for the machine timer window, plus the byte-lane merge
// shared by every writable register.
package platform_pkg;
  localparam logic [31:0] MTIMER_BASE_ADDR = 32'h0200_4000;
  localparam logic [31:0] MTIMER_MASK      = 32'hFFFF_FFE0;

  localparam logic [4:0] MTIME_LO_OFF    = 5'h00;
  localparam logic [4:0] MTIME_HI_OFF    = 5'h04;
  localparam logic [4:0] MTIMECMP_LO_OFF = 5'h08;
  localparam logic [4:0] MTIMECMP_HI_OFF = 5'h0C;
  localparam logic [4:0] CTRL_OFF        = 5'h10;

  localparam int CTRL_EN_BIT = 31;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction
endpackage

// File: rtl/wishbone_if.sv
// Wishbone pipelined bus, 32-bit data with byte selects.
interface wishbone_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        stall;

  modport SLAVE  (input cyc, stb, we, adr, sel, wdata, output rdata, ack, stall);
  modport MASTER (output cyc, stb, we, adr, sel, wdata, input rdata, ack, stall);
endinterface

// File: rtl/mtimer_prescaler.sv
// Divides the core clock into mtime ticks: one tick every reload_i+1 enabled cycles.
module mtimer_prescaler #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] reload_i,
  input  logic         clear_i,
  output logic         tick_o
);
  logic [W-1:0] r_cnt;

  assign tick_o = en_i && (r_cnt == reload_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        r_cnt <= '0;
    else if (clear_i) r_cnt <= '0;
    else if (en_i)    r_cnt <= tick_o ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/wb_mtimer.sv
// RISC-V machine timer (mtime/mtimecmp) as a Wishbone pipelined slave; drives the
// core's timer interrupt.
module wb_mtimer
  import platform_pkg::*;
#(
  parameter int PRESCALE_RST = 0,
  parameter int PRESCALE_W   = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  wishbone_if.SLAVE    wb_if,
  output logic         irq_timer_o
);
  logic [63:0]           r_mtime;
  logic [63:0]           r_cmp;
  logic                  r_en;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_ack;
  logic [31:0]           r_rdata;
  logic                  r_irq;

  logic        w_acc, w_wr, w_tick, w_ack;
  logic [4:0]  w_off;
  logic [31:0] w_ctrl, w_ctrl_new, w_rd, w_merge;
  logic        w_unused;

  assign w_acc    = wb_if.cyc & wb_if.stb;
  // sel=0 is acked but must not touch any state, including the prescale counter
  assign w_wr     = w_acc & wb_if.we & (|wb_if.sel);
  assign w_off    = {wb_if.adr[4:2], 2'b00};
  assign w_unused = ^{wb_if.adr[31:5], wb_if.adr[1:0]};

  always_comb begin
    w_ctrl                   = '0;
    w_ctrl[CTRL_EN_BIT]      = r_en;
    w_ctrl[PRESCALE_W-1:0]   = r_prescale;
  end

  assign w_ctrl_new = byte_merge(w_ctrl, wb_if.wdata, wb_if.sel);

  always_comb begin
    w_rd    = '0;
    w_merge = '0;
    case (w_off)
      MTIME_LO_OFF:    begin w_rd = r_mtime[31:0];  w_merge = byte_merge(r_mtime[31:0],  wb_if.wdata, wb_if.sel); end
      MTIME_HI_OFF:    begin w_rd = r_mtime[63:32]; w_merge = byte_merge(r_mtime[63:32], wb_if.wdata, wb_if.sel); end
      MTIMECMP_LO_OFF: begin w_rd = r_cmp[31:0];    w_merge = byte_merge(r_cmp[31:0],    wb_if.wdata, wb_if.sel); end
      MTIMECMP_HI_OFF: begin w_rd = r_cmp[63:32];   w_merge = byte_merge(r_cmp[63:32],   wb_if.wdata, wb_if.sel); end
      CTRL_OFF:        w_rd = w_ctrl;
      default:         w_rd = '0;
    endcase
  end

  mtimer_prescaler #(.W(PRESCALE_W)) u_presc (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (r_en),
    .reload_i (r_prescale),
    .clear_i  (w_wr && (w_off == CTRL_OFF)),
    .tick_o   (w_tick)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mtime    <= '0;
      r_cmp      <= '1;
      r_en       <= 1'b1;
      r_prescale <= PRESCALE_W'(PRESCALE_RST);
      r_ack      <= 1'b0;
      r_rdata    <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_ack   <= w_acc;
      r_rdata <= w_acc ? w_rd : '0;
      // compare on the registered values: a write or tick shows up one edge later
      r_irq   <= (r_mtime >= r_cmp);
      // a software write to either mtime half wins over that cycle's tick
      if (w_wr && w_off == MTIME_LO_OFF)      r_mtime[31:0]  <= w_merge;
      else if (w_wr && w_off == MTIME_HI_OFF) r_mtime[63:32] <= w_merge;
      else if (w_tick)                        r_mtime        <= r_mtime + 64'd1;
      if (w_wr && w_off == MTIMECMP_LO_OFF) r_cmp[31:0]  <= w_merge;
      if (w_wr && w_off == MTIMECMP_HI_OFF) r_cmp[63:32] <= w_merge;
      if (w_wr && w_off == CTRL_OFF) begin
        r_en       <= w_ctrl_new[CTRL_EN_BIT];
        r_prescale <= w_ctrl_new[PRESCALE_W-1:0];
      end
    end
  end

  assign w_ack       = r_ack & wb_if.cyc;
  assign wb_if.ack   = w_ack;
  assign wb_if.rdata = w_ack ? r_rdata : 32'h0;
  assign wb_if.stall = 1'b0;
  assign irq_timer_o = r_irq;
endmodule

// File: tb/tb_wb_mtimer.sv
// Directed bench for wb_mtimer: reset, prescale, carry/wrap, interrupt, bus protocol, collision.
module tb_wb_mtimer;
  import platform_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  int   total = 0;
  int   bad   = 0;

  wishbone_if bus();

  wb_mtimer #(.PRESCALE_RST(0), .PRESCALE_W(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .wb_if       (bus),
    .irq_timer_o (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] A(input logic [4:0] off);
    return MTIMER_BASE_ADDR | {27'h0, off};
  endfunction

  // one isolated transaction; returns what the bus showed in the ack cycle
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] wd, output logic ack, output logic [31:0] rd);
    @(posedge clk); #1;
    bus.cyc = 1; bus.stb = 1; bus.we = we; bus.adr = adr; bus.sel = sel; bus.wdata = wd;
    @(posedge clk); #1;
    ack = bus.ack; rd = bus.rdata;
    bus.stb = 0; bus.we = 0; bus.cyc = 0;
  endtask

  task automatic test_reset;
    logic ack; logic [31:0] rd;
    repeat (3) @(posedge clk); #1;
    total++; if (bus.ack !== 1'b0)    begin bad++; $display("FAIL rst_ack got=%b exp=0", bus.ack); end
    total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", bus.rdata); end
    total++; if (bus.stall !== 1'b0)  begin bad++; $display("FAIL rst_stall got=%b exp=0", bus.stall); end
    total++; if (irq !== 1'b0)        begin bad++; $display("FAIL rst_irq got=%b exp=0", irq); end
    rst = 0;
    wb_xfer(1, A(CTRL_OFF), 4'hF, 32'h0000_0005, ack, rd);
    wb_xfer(1, A(MTIMECMP_HI_OFF), 4'hF, 32'h0, ack, rd);
    @(posedge clk); #1;
    bus.cyc = 1; bus.stb = 1; bus.we = 0; bus.adr = A(CTRL_OFF); bus.sel = 4'hF;
    @(posedge clk); #1;
    rst = 1; #1;
    total++; if (bus.ack !== 1'b0) begin bad++; $display("FAIL rst_mid_ack got=%b exp=0", bus.ack); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++; if (bus.ack !== 1'b0) begin bad++; $display("FAIL rst_hold_ack got=%b exp=0", bus.ack); end
    end
    bus.cyc = 0; bus.stb = 0; rst = 0;
    wb_xfer(0, A(MTIME_LO_OFF), 4'hF, 0, ack, rd);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL rst_mtime_lo got=%h exp=1", rd); end
    wb_xfer(0, A(MTIMECMP_HI_OFF), 4'hF, 0, ack, rd);
    total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_cmp_hi got=%h exp=ffffffff", rd); end
    wb_xfer(0, A(CTRL_OFF), 4'hF, 0, ack, rd);
    total++; if (rd !== 32'h8000_0000 || ack !== 1'b1) begin bad++; $display("FAIL rst_ctrl got=%h/%b exp=80000000/1", rd, ack); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq_after got=%b exp=0", irq); end
  endtask

  task automatic test_prescale;
    logic ack; logic [31:0] rd;
    wb_xfer(1, A(CTRL_OFF), 4'hF, 32'h8000_0003, ack, rd);
    wb_xfer(1, A(MTIME_LO_OFF), 4'hF, 32'h0, ack, rd);
    repeat (40) @(posedge clk);
    wb_xfer(0, A(MTIME_LO_OFF), 4'hF, 0, ack, rd);
    total++; if (rd !== 32'd10) begin bad++; $display("FAIL presc_count got=%0d exp=10", rd); end
    wb_xfer(1, A(CTRL_OFF), 4'hF, 32'h0000_0003, ack, rd);
    repeat (100) @(posedge clk);
    wb_xfer(0, A(MTIME_LO_OFF), 4'hF, 0, ack, rd);
    total++; if (rd !== 32'd11) begin bad++; $display("FAIL presc_frozen got=%0d exp=11", rd); end
    wb_xfer(0, A(CTRL_OFF), 4'hF, 0, ack, rd);
    total++; if (rd !== 32'h0000_0003) begin bad++; $display("FAIL presc_ctrl got=%h exp=00000003", rd); end
  endtask

  task automatic test_carry_wrap;
    logic ack; logic [31:0] rd;
    wb_xfer(1, A(CTRL_OFF), 4'hF, 32'h8000_0000, ack, rd);
    wb_xfer(1, A(MTIME_HI_OFF), 4'hF, 32'h0, ack, rd);
    wb_xfer(1, A(MTIME_LO_OFF), 4'hF, 32'hFFFF_FFFE, ack, rd);
    @(posedge clk);
    wb_xfer(0, A(MTIME_HI_OFF), 4'hF, 0, ack, rd);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL carry_hi got=%h exp=1", rd); end
    wb_xfer(0, A(MTIME_LO_OFF), 4'hF, 0, ack, rd);
    total++; if (rd !== 32'h2) begin bad++; $display("FAIL carry_lo got=%h exp=2", rd); end
    wb_xfer(1, A(CTRL_OFF), 4'hF, 32'h0, ack, rd);
    wb_xfer(1, A(MTIME_HI_OFF), 4'hF, 32'hFFFF_FFFF, ack, rd);
    wb_xfer(1, A(MTIME_LO_OFF), 4'hF, 32'hFFFF_FFFF, ack, rd);
    wb_xfer(0, A(MTIME_LO_OFF), 4'hF, 0, ack, rd);
    total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_pre_lo got=%h exp=ffffffff", rd); end
    wb_xfer(1, A(CTRL_OFF), 4'hF, 32'h8000_0000, ack, rd);
    wb_xfer(0, A(MTIME_LO_OFF), 4'hF, 0, ack, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL wrap_lo got=%h exp=0", rd); end
    wb_xfer(0, A(MTIME_HI_OFF), 4'hF, 0, ack, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL wrap_hi got=%h exp=0", rd); end
  endtask

  task automatic test_interrupt;
    logic ack; logic [31:0] rd;
    wb_xfer(1, A(CTRL_OFF), 4'hF, 32'h0, ack, rd);
    wb_xfer(1, A(MTIME_LO_OFF), 4'hF, 32'h0, ack, rd);
    wb_xfer(1, A(MTIME_HI_OFF), 4'hF, 32'h0, ack, rd);
    wb_xfer(1, A(MTIMECMP_LO_OFF), 4'hF, 32'h64, ack, rd);
    wb_xfer(1, A(MTIMECMP_HI_OFF), 4'hF, 32'h0, ack, rd);
    repeat (2) @(posedge clk); #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_idle got=%b exp=0", irq); end
    wb_xfer(1, A(CTRL_OFF), 4'hF, 32'h8000_0000, ack, rd);
    repeat (100) @(posedge clk); #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_early got=%b exp=0", irq); end
    @(posedge clk); #1;
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b exp=1", irq); end
    wb_xfer(1, A(MTIMECMP_HI_OFF), 4'hF, 32'h1, ack, rd);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_hold got=%b exp=1", irq); end
    @(posedge clk); #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_fall got=%b exp=0", irq); end
  endtask

  task automatic test_bus;
    logic ack; logic [31:0] rd;
    logic [4:0]  offs [4] = '{MTIMECMP_LO_OFF, MTIMECMP_HI_OFF, CTRL_OFF, 5'h18};
    logic [31:0] exps [4] = '{32'h64, 32'h1, 32'h0, 32'h0};
    wb_xfer(1, A(CTRL_OFF), 4'hF, 32'h0, ack, rd);
    @(posedge clk); #1;
    bus.cyc = 1; bus.stb = 1; bus.we = 0; bus.sel = 4'hF; bus.adr = A(offs[0]);
    for (int i = 1; i <= 4; i++) begin
      total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%b exp=0", bus.stall); end
      @(posedge clk); #1;
      total++;
      if (bus.ack !== 1'b1 || bus.rdata !== exps[i-1]) begin
        bad++; $display("FAIL b2b_read%0d got=%b/%h exp=1/%h", i-1, bus.ack, bus.rdata, exps[i-1]);
      end
      if (i < 4) bus.adr = A(offs[i]); else bus.stb = 0;
    end
    bus.cyc = 0;
    wb_xfer(1, A(MTIMECMP_LO_OFF), 4'hF, 32'hFFFF_FFFF, ack, rd);
    wb_xfer(1, A(MTIMECMP_LO_OFF), 4'b0010, 32'h0000_AB00, ack, rd);
    wb_xfer(0, A(MTIMECMP_LO_OFF), 4'hF, 0, ack, rd);
    total++; if (rd !== 32'hFFFF_ABFF) begin bad++; $display("FAIL byte_write got=%h exp=ffffabff", rd); end
    wb_xfer(1, A(MTIMECMP_HI_OFF), 4'b0000, 32'hDEAD_BEEF, ack, rd);
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL sel0_ack got=%b exp=1", ack); end
    wb_xfer(0, A(MTIMECMP_HI_OFF), 4'hF, 0, ack, rd);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL sel0_nochange got=%h exp=1", rd); end
    wb_xfer(1, A(5'h18), 4'hF, 32'hFFFF_FFFF, ack, rd);
    wb_xfer(0, A(5'h18), 4'hF, 0, ack, rd);
    total++; if (rd !== 32'h0 || ack !== 1'b1) begin bad++; $display("FAIL unmapped got=%h/%b exp=0/1", rd, ack); end
    @(posedge clk); #1;
    bus.cyc = 1; bus.stb = 1; bus.we = 0; bus.adr = A(MTIMECMP_HI_OFF);
    @(posedge clk); #1;
    bus.cyc = 0; bus.stb = 0; #1;
    total++; if (bus.ack !== 1'b0 || bus.rdata !== 32'h0) begin bad++; $display("FAIL cyc_drop got=%b/%h exp=0/0", bus.ack, bus.rdata); end
  endtask

  task automatic test_collision;
    logic ack; logic [31:0] rd;
    wb_xfer(1, A(MTIME_HI_OFF), 4'hF, 32'h12, ack, rd);
    wb_xfer(1, A(MTIME_LO_OFF), 4'hF, 32'h0, ack, rd);
    wb_xfer(1, A(CTRL_OFF), 4'hF, 32'h8000_0000, ack, rd);
    @(posedge clk); #1;
    bus.cyc = 1; bus.stb = 1; bus.we = 1; bus.sel = 4'hF; bus.adr = A(MTIME_LO_OFF); bus.wdata = 32'h5;
    @(posedge clk); #1;
    total++; if (bus.ack !== 1'b1) begin bad++; $display("FAIL coll_wr_ack got=%b exp=1", bus.ack); end
    bus.we = 0;
    @(posedge clk); #1;
    total++; if (bus.rdata !== 32'h5) begin bad++; $display("FAIL coll_lo got=%h exp=5", bus.rdata); end
    bus.adr = A(MTIME_HI_OFF);
    @(posedge clk); #1;
    total++; if (bus.rdata !== 32'h12) begin bad++; $display("FAIL coll_hi got=%h exp=12", bus.rdata); end
    bus.stb = 0; bus.cyc = 0;
  endtask

  initial begin
    bus.cyc = 0; bus.stb = 0; bus.we = 0; bus.adr = '0; bus.sel = '0; bus.wdata = '0;
    test_reset();
    test_prescale();
    test_carry_wrap();
    test_interrupt();
    test_bus();
    test_collision();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
